// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and transfer sequencer: grants one master, drives the
// selected slave's read/write enable and waits for completion. Optional timeout: ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MASTERS-1:0]     m_req,
    input  logic [NUM_MASTERS-1:0]     m_rw,
    input  logic [2*NUM_MASTERS-1:0]   m_sid,
    output logic [NUM_MASTERS-1:0]     m_grant,
    output logic [NUM_MASTERS-1:0]     m_done,
    output logic [NUM_MASTERS-1:0]     m_error,
    output logic [NUM_SLAVES-1:0]      s_write_en,
    output logic [NUM_SLAVES-1:0]      s_read_en,
    input  logic [NUM_SLAVES-1:0]      s_rx_done,
    input  logic [NUM_SLAVES-1:0]      s_tx_done,
    output logic                       bus_busy
);

    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SW = 2;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || NUM_SLAVES < 1 || NUM_SLAVES > 4 || TIMEOUT < 1) begin : g_param_check
        $error("bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          rr_q, rr_d, cur_m_q, cur_m_d;
    logic                   cur_rw_q, cur_rw_d;
    logic [SW-1:0]          cur_sid_q, cur_sid_d;
    logic [NUM_MASTERS-1:0] grant_d, done_d, err_d;
    logic [NUM_SLAVES-1:0]  wen_d, ren_d;

    logic                   win_found, win_rw, win_valid;
    logic [MW-1:0]          win_m;
    logic [SW-1:0]          win_sid;
    logic                   slave_hit, cur_req, timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero on XFER entry and advances once per XFER cycle
    always_comb begin
        cnt_d = '0;
        if (state_q == XFER) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // Rotating-priority search starting at rr_q
    always_comb begin
        win_found = 1'b0;
        win_m     = '0;
        win_rw    = 1'b0;
        win_sid   = '0;
        for (int off = 0; off < int'(NUM_MASTERS); off++) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (!win_found && m_req[i] && (i == ((int'(rr_q) + off) % int'(NUM_MASTERS)))) begin
                    win_found = 1'b1;
                    win_m     = MW'(i);
                    win_rw    = m_rw[i];
                    win_sid   = m_sid[2*i +: 2];
                end
            end
        end
        win_valid = (int'(win_sid) < int'(NUM_SLAVES));
    end

    // Completion from the selected slave in the latched direction; request level of the owner
    always_comb begin
        slave_hit = 1'b0;
        cur_req   = 1'b0;
        for (int j = 0; j < int'(NUM_SLAVES); j++) begin
            if (cur_sid_q == SW'(j)) slave_hit = cur_rw_q ? s_rx_done[j] : s_tx_done[j];
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (cur_m_q == MW'(i)) cur_req = m_req[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cur_m_d   = cur_m_q;
        cur_rw_d  = cur_rw_q;
        cur_sid_d = cur_sid_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = '0;
        wen_d     = '0;
        ren_d     = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    cur_m_d   = win_m;
                    cur_rw_d  = win_rw;
                    cur_sid_d = win_sid;
                    rr_d      = (int'(win_m) == int'(NUM_MASTERS) - 1) ? '0 : win_m + MW'(1);
                    if (win_valid) begin
                        state_d = XFER;
                    end else begin
                        state_d = DONE;
                        for (int i = 0; i < int'(NUM_MASTERS); i++) err_d[i] = (win_m == MW'(i));
                    end
                end
            end
            XFER: begin
                if (slave_hit) begin
                    state_d = DONE;
                    for (int i = 0; i < int'(NUM_MASTERS); i++) done_d[i] = (cur_m_q == MW'(i));
                end else if (!cur_req || timeout_hit) begin
                    state_d = DONE;
                    for (int i = 0; i < int'(NUM_MASTERS); i++) err_d[i] = (cur_m_q == MW'(i));
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Grant and enables follow the next state so they register together with it
        if (state_d == XFER) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) grant_d[i] = (cur_m_d == MW'(i));
            for (int j = 0; j < int'(NUM_SLAVES); j++) begin
                if (cur_sid_d == SW'(j)) begin
                    wen_d[j] = cur_rw_d;
                    ren_d[j] = !cur_rw_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cur_m_q    <= '0;
            cur_rw_q   <= 1'b0;
            cur_sid_q  <= '0;
            m_grant    <= '0;
            m_done     <= '0;
            m_error    <= '0;
            s_write_en <= '0;
            s_read_en  <= '0;
            bus_busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_m_q    <= cur_m_d;
            cur_rw_q   <= cur_rw_d;
            cur_sid_q  <= cur_sid_d;
            m_grant    <= grant_d;
            m_done     <= done_d;
            m_error    <= err_d;
            s_write_en <= wen_d;
            s_read_en  <= ren_d;
            bus_busy   <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (2 masters, 3 slaves, TIMEOUT=4); covers both ARB_TIMEOUT_EN builds.
module tb_bus_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned NS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] m_req, m_rw, m_grant, m_done, m_error;
    logic [2*NM-1:0] m_sid;
    logic [NS-1:0] s_write_en, s_read_en, s_rx_done, s_tx_done;
    logic          bus_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_rw(m_rw), .m_sid(m_sid),
        .m_grant(m_grant), .m_done(m_done), .m_error(m_error),
        .s_write_en(s_write_en), .s_read_en(s_read_en),
        .s_rx_done(s_rx_done), .s_tx_done(s_tx_done),
        .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled mid-cycle
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        int         g;

        reset = 1'b0; m_req = '0; m_rw = '0; m_sid = '0; s_rx_done = '0; s_tx_done = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(m_grant), 32'h0);
        check("rst_done_err", 32'({m_done, m_error}), 32'h0);
        check("rst_en", 32'({s_write_en, s_read_en}), 32'h0);
        check("rst_busy", 32'(bus_busy), 32'h0);
        reset = 1'b1;
        tick;

        // Single write: master 0 -> slave 2
        m_req = 2'b01; m_rw = 2'b01; m_sid = 4'b0010;
        tick;
        check("wr_grant", 32'(m_grant), 32'h1);
        check("wr_wen", 32'(s_write_en), 32'h4);
        check("wr_ren", 32'(s_read_en), 32'h0);
        check("wr_busy", 32'(bus_busy), 32'h1);
        tick;
        check("wr_hold", 32'(m_grant), 32'h1);
        s_rx_done = 3'b100;
        tick;
        s_rx_done = '0; m_req = '0;
        check("wr_rel_grant", 32'(m_grant), 32'h0);
        check("wr_rel_wen", 32'(s_write_en), 32'h0);
        check("wr_done", 32'(m_done), 32'h1);
        check("wr_done_busy", 32'(bus_busy), 32'h1);
        tick;
        check("wr_done_clr", 32'(m_done), 32'h0);
        check("wr_idle_busy", 32'(bus_busy), 32'h0);

        // Round robin: both request reads, m0->sid0, m1->sid1; rr_ptr is 1 now
        m_req = 2'b11; m_rw = 2'b00; m_sid = 4'b0100;
        exp_g = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_grant", 32'(m_grant), 32'(exp_g));
            check("rr_ren", 32'(s_read_en), (exp_g == 2'b01) ? 32'h1 : 32'h2);
            s_tx_done = (exp_g == 2'b01) ? 3'b001 : 3'b010;
            if (k == 3) m_req = '0;  // drop together with completion: completion wins
            tick;
            s_tx_done = '0;
            check("rr_done", 32'(m_done), 32'(exp_g));
            check("rr_rel_grant", 32'(m_grant), 32'h0);
            tick;
            check("rr_gap_grant", 32'(m_grant), 32'h0);
            check("rr_gap_busy", 32'(bus_busy), 32'h0);
            exp_g = ~exp_g;
        end

        // Invalid slave ID from master 1
        m_req = 2'b10; m_rw = 2'b10; m_sid = 4'b1100;
        tick;
        check("inv_err", 32'(m_error), 32'h2);
        check("inv_grant", 32'(m_grant), 32'h0);
        check("inv_en", 32'({s_write_en, s_read_en}), 32'h0);
        check("inv_busy", 32'(bus_busy), 32'h1);
        m_req = '0;
        tick;
        check("inv_err_clr", 32'(m_error), 32'h0);
        check("inv_idle", 32'({m_grant, bus_busy}), 32'h0);

        // Wrong-done pulses ignored, master changes ignored, then abort
        m_req = 2'b01; m_rw = 2'b00; m_sid = 4'b0001;
        tick;
        check("ab_grant", 32'(m_grant), 32'h1);
        check("ab_ren", 32'(s_read_en), 32'h2);
        s_rx_done = 3'b010; s_tx_done = 3'b001; m_rw = 2'b01; m_sid = 4'b0010;
        tick;
        s_rx_done = '0; s_tx_done = '0;
        check("ab_hold", 32'(m_grant), 32'h1);
        check("ab_ren_latched", 32'(s_read_en), 32'h2);
        check("ab_wen_latched", 32'(s_write_en), 32'h0);
        check("ab_no_done", 32'(m_done), 32'h0);
        m_req = '0;
        tick;
        check("ab_err", 32'(m_error), 32'h1);
        check("ab_done", 32'(m_done), 32'h0);
        check("ab_rel", 32'(m_grant), 32'h0);
        tick;

        // Silent slave: timeout or indefinite hold
        m_req = 2'b01; m_rw = 2'b00; m_sid = 4'b0000;
        tick;
        check("to_grant", 32'(m_grant), 32'h1);
`ifdef ARB_TIMEOUT_EN
        g = 1;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (m_grant == 2'b01) g++;
            else break;
        end
        check("to_cycles", 32'(g), 32'd5);
        check("to_err", 32'(m_error), 32'h1);
        m_req = '0;
        tick;
        check("to_err_clr", 32'(m_error), 32'h0);
`else
        g = 0;
        repeat (20) tick;
        check("to_hold", 32'(m_grant), 32'h1);
        m_req = '0;
        tick;
        check("to_abort_err", 32'(m_error), 32'h1);
        tick;
`endif

        // Async reset mid-transfer with rr_ptr = 1
        m_req = 2'b10; m_rw = 2'b10; m_sid = 4'b0000;
        tick;
        check("mr_grant", 32'(m_grant), 32'h2);
        check("mr_wen", 32'(s_write_en), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mr_outs", 32'({m_grant, m_done, m_error, s_write_en, s_read_en}), 32'h0);
        check("mr_busy", 32'(bus_busy), 32'h0);
        @(negedge clk);
        check("mr_no_pulse", 32'({m_done, m_error}), 32'h0);
        reset = 1'b1; m_req = 2'b11; m_rw = 2'b00; m_sid = 4'b0100;
        tick;
        check("mr_rr0_grant", 32'(m_grant), 32'h1);
        check("mr_rr0_ren", 32'(s_read_en), 32'h1);
        check("mr_no_pulse2", 32'({m_done, m_error}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
